// File: rtl/spi_regbank.sv
// spi_regbank: SPI mode-0 slave register bank with burst auto-increment and one live read-only register.
//   clk_ref/sys_rst : fabric clock (>= 8x spi_sclk), synchronous active-high reset
//   spi_ss_n/spi_sclk/spi_mosi/spi_miso : SPI pins; frame = CMD(8) ADDR(ADDR_W) DATA(DATA_W)..., 0x03 write, 0x04 read
//   live_valid/live_data : loads register LIVE_ADDR every cycle live_valid is high
//   regs_flat : all registers, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe/wr_addr/wr_data : one-cycle report of each committed SPI write
//   SPI_REGBANK_BURST_EN : when defined, unlimited words per frame; otherwise one word then drain
module spi_regbank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NUM_REGS = 16,
  parameter int LIVE_ADDR = 7,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS = '0
) (
  input  logic                       clk_ref,
  input  logic                       sys_rst,
  input  logic                       spi_ss_n,
  input  logic                       spi_sclk,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  input  logic                       live_valid,
  input  logic [DATA_W-1:0]          live_data,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data
);
`ifdef SPI_REGBANK_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int AW = ADDR_W > 8 ? ADDR_W : 8;
  localparam int RW = DATA_W > AW ? DATA_W : AW;
  localparam int CW = $clog2(RW + 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WR, RD, DRAIN} state_t;
  state_t state, state_nxt;
  logic [2:0] ss_q, sclk_q;
  logic [1:0] mosi_q;
  logic [RW-1:0] rx, rx_nxt;
  logic [DATA_W-1:0] tx, word;
  logic [CW-1:0] cnt, len;
  logic [7:0] cmd;
  logic [ADDR_W-1:0] addr, addr_inc, new_addr;
  logic rise, fall, ss_rise, ss_fall, shifting, done, wr_ok;
  // [0],[1] synchronize; [2] is the edge-detect history
  assign rise = sclk_q[1] & ~sclk_q[2];
  assign fall = ~sclk_q[1] & sclk_q[2];
  assign ss_rise = ss_q[1] & ~ss_q[2];
  assign ss_fall = ~ss_q[1] & ss_q[2];
  assign rx_nxt = {rx[RW-2:0], mosi_q[1]};
  assign word = rx_nxt[DATA_W-1:0];
  assign new_addr = rx_nxt[ADDR_W-1:0];
  assign shifting = state inside {CMD, ADDR, WR, RD};
  assign len = CW'(state == CMD ? 8 : state == ADDR ? ADDR_W : DATA_W);
  assign done = rise && shifting && cnt == len - 1'b1;
  assign addr_inc = addr == ADDR_W'(NUM_REGS - 1) ? '0 : addr + 1'b1;
  assign wr_ok = 32'(addr) < NUM_REGS && 32'(addr) != LIVE_ADDR;
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS ? regs_flat[32'(a[IW-1:0]) * DATA_W +: DATA_W] : '0;
  endfunction
  always_ff @(posedge clk_ref) begin
    if (sys_rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (ss_rise) state_nxt = IDLE;
    else if (state == IDLE && ss_fall) state_nxt = CMD;
    else if (done) state_nxt = state == CMD ? ADDR :
                               state == ADDR ? (cmd == 8'h03 ? WR : cmd == 8'h04 ? RD : DRAIN) :
                               BURST ? state : DRAIN;
  end
  always_ff @(posedge clk_ref) begin
    if (sys_rst) begin
      // ss_n history resets low so a frame already in progress never looks like a fresh ss_n fall
      ss_q <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
      rx <= '0;
      tx <= '0;
      cnt <= '0;
      cmd <= '0;
      addr <= '0;
      regs_flat <= RST_VALS;
      spi_miso <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      ss_q <= {ss_q[1:0], spi_ss_n};
      sclk_q <= {sclk_q[1:0], spi_sclk};
      mosi_q <= {mosi_q[0], spi_mosi};
      wr_strobe <= 1'b0;
      if (rise && shifting) begin
        rx <= rx_nxt;
        cnt <= done ? '0 : cnt + 1'b1;
      end
      if (state == IDLE) cnt <= '0;
      if (done && state == CMD) cmd <= rx_nxt[7:0];
      if (done && state == ADDR) begin
        addr <= new_addr;
        tx <= rd_val(new_addr);
      end
      if (done && state == RD) begin
        addr <= addr_inc;
        tx <= rd_val(addr_inc);
      end
      if (live_valid) regs_flat[LIVE_ADDR*DATA_W +: DATA_W] <= live_data;
      if (done && state == WR) begin
        addr <= addr_inc;
        if (wr_ok) begin
          regs_flat[32'(addr[IW-1:0]) * DATA_W +: DATA_W] <= word;
          wr_strobe <= 1'b1;
          wr_addr <= addr;
          wr_data <= word;
        end
      end
      if (state != RD) spi_miso <= 1'b0;
      else if (fall) begin
        spi_miso <= tx[DATA_W-1];
        tx <= tx << 1;
      end
    end
  end
endmodule
